axi4_w_req_arb: RTL and testbench

- Shares one AXI4 write-master bridge between NREQ write requesters, e.g. DMA channels or the QEMU host-write path.
- Arbitrates round-robin and forwards the winner's address, length and size as a one-cycle request pulse.
- Drives the data/strobe mux select and holds exactly one write in flight until the write response returns.
- Reports per-transaction completion back to the originating requester.

---
 rtl/axi4_w_req_arb.sv | 146 ++++++++++++++
 tb/tb_axi4_w_req_arb.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_w_req_arb.sv
// axi4_w_req_arb: shares one AXI4 write-master bridge between NREQ requesters.
// Round-robin arbitration, a one-cycle request pulse to the master, and one
// write in flight until its B response returns. Completion is reported back
// with the requester index and the response code.
// Optional build macro AXI4_W_ARB_TIMEOUT_EN adds a response timeout of
// TO_CYC cycles in WAIT_B and the sticky o_timeout output.
module axi4_w_req_arb #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned ADRW   = 32,
    parameter int unsigned TO_CYC = 1024,
    localparam int unsigned IDW   = $clog2(NREQ)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NREQ-1:0]   i_req_valid,
    output logic [NREQ-1:0]   o_req_ready,
    input  logic [NREQ*ADRW-1:0] i_req_addr,
    input  logic [NREQ*8-1:0] i_req_len,
    input  logic [NREQ*3-1:0] i_req_size,
    output logic [IDW-1:0]    o_grant_sel,
    output logic              o_m_req_valid,
    output logic [ADRW-1:0]   o_m_req_addr,
    output logic [7:0]        o_m_req_len,
    output logic [2:0]        o_m_req_size,
    input  logic              i_m_bvalid,
    input  logic [1:0]        i_m_bresp,
    output logic              o_done_valid,
    output logic [IDW-1:0]    o_done_id,
    output logic [1:0]        o_done_resp,
    output logic              o_busy
`ifdef AXI4_W_ARB_TIMEOUT_EN
    ,
    output logic              o_timeout
`endif
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWaitB = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e          state_q;
    logic [IDW-1:0]  ptr_q;
    logic            arb_found;
    logic [IDW-1:0]  arb_win;
    int unsigned     arb_idx;

`ifdef AXI4_W_ARB_TIMEOUT_EN
    localparam int unsigned CNTW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    logic [CNTW-1:0] to_cnt_q;
`endif

    // Round-robin pick: first valid requester at or above the pointer, with wrap.
    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        arb_idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            arb_idx = (32'(ptr_q) + 32'(i)) % NREQ;
            if (!arb_found && i_req_valid[arb_idx]) begin
                arb_found = 1'b1;
                arb_win   = IDW'(arb_idx);
            end
        end
    end

    // Control FSM; all outputs are registered and reflect the state being entered.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            o_req_ready   <= '0;
            o_grant_sel   <= '0;
            o_m_req_valid <= 1'b0;
            o_m_req_addr  <= '0;
            o_m_req_len   <= '0;
            o_m_req_size  <= '0;
            o_done_valid  <= 1'b0;
            o_done_id     <= '0;
            o_done_resp   <= '0;
            o_busy        <= 1'b0;
`ifdef AXI4_W_ARB_TIMEOUT_EN
            to_cnt_q      <= '0;
            o_timeout     <= 1'b0;
`endif
        end else begin
            // Pulses default low; only the entering transition raises them.
            o_req_ready   <= '0;
            o_m_req_valid <= 1'b0;
            o_done_valid  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (arb_found) begin
                        o_req_ready   <= NREQ'(1) << arb_win;
                        o_grant_sel   <= arb_win;
                        o_m_req_addr  <= i_req_addr[32'(arb_win) * ADRW +: ADRW];
                        o_m_req_len   <= i_req_len[32'(arb_win) * 8 +: 8];
                        o_m_req_size  <= i_req_size[32'(arb_win) * 3 +: 3];
                        o_m_req_valid <= 1'b1;
                        o_busy        <= 1'b1;
                        state_q       <= StIssue;
                    end
                end
                StIssue: begin
                    // The B response cannot arrive yet, so bvalid is not looked at.
`ifdef AXI4_W_ARB_TIMEOUT_EN
                    to_cnt_q <= '0;
`endif
                    state_q <= StWaitB;
                end
                StWaitB: begin
                    if (i_m_bvalid) begin
                        o_done_valid <= 1'b1;
                        o_done_id    <= o_grant_sel;
                        o_done_resp  <= i_m_bresp;
                        state_q      <= StDone;
                    end
`ifdef AXI4_W_ARB_TIMEOUT_EN
                    else if (to_cnt_q == CNTW'(TO_CYC - 1)) begin
                        o_done_valid <= 1'b1;
                        o_done_id    <= o_grant_sel;
                        o_done_resp  <= 2'b11;
                        o_timeout    <= 1'b1;
                        state_q      <= StDone;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
`endif
                end
                StDone: begin
                    if (o_grant_sel == IDW'(NREQ - 1)) begin
                        ptr_q <= '0;
                    end else begin
                        ptr_q <= o_grant_sel + 1'b1;
                    end
                    o_busy  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_w_req_arb.sv
// Directed bench for axi4_w_req_arb with NREQ=4, ADRW=32.
module tb_axi4_w_req_arb;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_addr;
    logic [31:0]  req_len;
    logic [11:0]  req_size;
    logic [1:0]   grant_sel;
    logic         m_req_valid;
    logic [31:0]  m_req_addr;
    logic [7:0]   m_req_len;
    logic [2:0]   m_req_size;
    logic         bvalid;
    logic [1:0]   bresp;
    logic         done_valid;
    logic [1:0]   done_id;
    logic [1:0]   done_resp;
    logic         busy;
`ifdef AXI4_W_ARB_TIMEOUT_EN
    logic         timeout;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] addr_tab [4];
    logic [7:0]  len_tab  [4];
    logic [2:0]  size_tab [4];

    axi4_w_req_arb #(
        .NREQ   (4),
        .ADRW   (32),
`ifdef AXI4_W_ARB_TIMEOUT_EN
        .TO_CYC (16)
`else
        .TO_CYC (1024)
`endif
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_addr    (req_addr),
        .i_req_len     (req_len),
        .i_req_size    (req_size),
        .o_grant_sel   (grant_sel),
        .o_m_req_valid (m_req_valid),
        .o_m_req_addr  (m_req_addr),
        .o_m_req_len   (m_req_len),
        .o_m_req_size  (m_req_size),
        .i_m_bvalid    (bvalid),
        .i_m_bresp     (bresp),
        .o_done_valid  (done_valid),
        .o_done_id     (done_id),
        .o_done_resp   (done_resp),
        .o_busy        (busy)
`ifdef AXI4_W_ARB_TIMEOUT_EN
        ,
        .o_timeout     (timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction starting in IDLE with the winner's request present.
    task automatic do_txn(input int id, input logic [1:0] resp, input int lat, input bit drop);
        step();
        chk("ready", 64'(req_ready), 64'(4'b0001 << id));
        chk("mvalid_hi", 64'(m_req_valid), 64'd1);
        chk("grant", 64'(grant_sel), 64'(id));
        chk("addr", 64'(m_req_addr), 64'(addr_tab[id]));
        chk("len", 64'(m_req_len), 64'(len_tab[id]));
        chk("size", 64'(m_req_size), 64'(size_tab[id]));
        if (drop) req_valid[id] = 1'b0;
        step();
        chk("mvalid_lo", 64'(m_req_valid), 64'd0);
        chk("ready_lo", 64'(req_ready), 64'd0);
        repeat (lat) step();
        chk("no_done_early", 64'(done_valid), 64'd0);
        bvalid = 1'b1;
        bresp  = resp;
        step();
        bvalid = 1'b0;
        bresp  = 2'b00;
        chk("done", 64'(done_valid), 64'd1);
        chk("done_id", 64'(done_id), 64'(id));
        chk("done_resp", 64'(done_resp), 64'(resp));
        chk("grant_hold", 64'(grant_sel), 64'(id));
        step();
        chk("done_lo", 64'(done_valid), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        addr_tab[0] = 32'h2000_0000; len_tab[0] = 8'd0;   size_tab[0] = 3'd2;
        addr_tab[1] = 32'h3000_0100; len_tab[1] = 8'd15;  size_tab[1] = 3'd3;
        addr_tab[2] = 32'h1000_0040; len_tab[2] = 8'd3;   size_tab[2] = 3'b101;
        addr_tab[3] = 32'h4000_0FC0; len_tab[3] = 8'd255; size_tab[3] = 3'd0;
        for (int k = 0; k < 4; k++) begin
            req_addr[k*32 +: 32] = addr_tab[k];
            req_len[k*8 +: 8]    = len_tab[k];
            req_size[k*3 +: 3]   = size_tab[k];
        end
        rst_n     = 1'b0;
        req_valid = '0;
        bvalid    = 1'b0;
        bresp     = 2'b00;
        step();
        step();
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_mvalid", 64'(m_req_valid), 64'd0);
        chk("rst_grant", 64'(grant_sel), 64'd0);
        chk("rst_addr", 64'(m_req_addr), 64'd0);
        chk("rst_done", 64'(done_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        step();

        // Single request from requester 2.
        req_valid = 4'b0100;
        do_txn(2, 2'b00, 0, 1'b1);

        // Requester 3 alone brings the pointer back to 0.
        req_valid = 4'b1000;
        do_txn(3, 2'b00, 2, 1'b1);

        // All valid continuously: strict 0,1,2,3 rotation.
        req_valid = 4'b1111;
        for (int n = 0; n < 8; n++) do_txn(n % 4, 2'b00, n % 3, 1'b0);

        // Pointer wrap after 3: requesters 1 and 3 alternate; last one errors.
        req_valid = 4'b1010;
        do_txn(1, 2'b00, 0, 1'b0);
        do_txn(3, 2'b00, 1, 1'b0);
        do_txn(1, 2'b10, 0, 1'b1);
        req_valid = 4'b0000;

        // Spurious bvalid while idle.
        bvalid = 1'b1;
        bresp  = 2'b11;
        step();
        chk("spur_idle_done", 64'(done_valid), 64'd0);
        step();
        chk("spur_idle_busy", 64'(busy), 64'd0);
        bvalid = 1'b0;
        bresp  = 2'b00;

        // Spurious bvalid in ISSUE is not taken as the response.
        req_valid = 4'b0100;
        step();
        chk("spur_iss_grant", 64'(grant_sel), 64'd2);
        req_valid = 4'b0000;
        bvalid    = 1'b1;
        step();
        bvalid = 1'b0;
        chk("spur_iss_done", 64'(done_valid), 64'd0);
        chk("spur_iss_busy", 64'(busy), 64'd1);
        step();
        chk("spur_iss_wait", 64'(done_valid), 64'd0);
        bvalid = 1'b1;
        bresp  = 2'b01;
        step();
        bvalid = 1'b0;
        bresp  = 2'b00;
        chk("spur_iss_fin", 64'(done_valid), 64'd1);
        chk("spur_iss_resp", 64'(done_resp), 64'd1);
        step();

        // Pointer at 3; requester 1 wins via wrap, pointer moves to 2.
        req_valid = 4'b0010;
        do_txn(1, 2'b00, 0, 1'b1);

        // Reset while in WAIT_B.
        req_valid = 4'b0100;
        step();
        chk("rstw_grant", 64'(grant_sel), 64'd2);
        req_valid = 4'b0000;
        step();
        chk("rstw_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        step();
        chk("rstw_grant0", 64'(grant_sel), 64'd0);
        chk("rstw_addr0", 64'(m_req_addr), 64'd0);
        chk("rstw_len0", 64'(m_req_len), 64'd0);
        chk("rstw_size0", 64'(m_req_size), 64'd0);
        chk("rstw_busy0", 64'(busy), 64'd0);
        chk("rstw_resp0", 64'(done_resp), 64'd0);
        rst_n = 1'b1;
        step();
        // Pointer cleared: requester 0 wins over 2.
        req_valid = 4'b1111;
        do_txn(0, 2'b00, 0, 1'b0);
        req_valid = 4'b0000;

`ifdef AXI4_W_ARB_TIMEOUT_EN
        chk("to_init", 64'(timeout), 64'd0);
        req_valid = 4'b0001;
        step();
        chk("to_grant", 64'(grant_sel), 64'd0);
        req_valid = 4'b0000;
        step();
        repeat (15) step();
        chk("to_not_yet", 64'(done_valid), 64'd0);
        step();
        chk("to_done", 64'(done_valid), 64'd1);
        chk("to_resp", 64'(done_resp), 64'd3);
        chk("to_flag", 64'(timeout), 64'd1);
        bvalid = 1'b1;
        step();
        bvalid = 1'b0;
        step();
        chk("to_sticky", 64'(timeout), 64'd1);
        chk("to_late_ign", 64'(done_valid), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
